// File: rtl/rf_dump_reader.sv
// Walks a register index range through a combinational read port and streams {index, value} words out.
// First word valid one cycle after start is taken; a word is held stable until out_ready, then the next index is read.
module rf_dump_reader #(
   parameter int A_WIDTH = 5,
   parameter int D_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [A_WIDTH-1:0] first_addr,
   input  logic [A_WIDTH-1:0] last_addr,
   output logic [A_WIDTH-1:0] rd_addr,
   input  logic [D_WIDTH-1:0] rd_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [A_WIDTH-1:0] out_addr,
   output logic [D_WIDTH-1:0] out_data,
   output logic               out_last,
   output logic               busy,
   output logic               done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_READ = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic [1:0]         state;
   logic [A_WIDTH-1:0] ptr;
   logic [A_WIDTH-1:0] last_q;

   assign busy    = (state != S_IDLE);
   assign rd_addr = (state == S_IDLE) ? '0 : ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         ptr       <= '0;
         last_q    <= '0;
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
         out_last  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  last_q <= last_addr;
                  ptr    <= first_addr;
                  state  <= S_READ;
               end
            end
            S_READ: begin
               // Value is snapshotted here; later writes to this index are not reflected.
               out_data  <= rd_data;
               out_addr  <= ptr;
               out_last  <= (ptr == last_q);
               out_valid <= 1'b1;
               state     <= S_HOLD;
            end
            S_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (out_last) begin
                     done  <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     ptr   <= ptr + A_WIDTH'(1);
                     state <= S_READ;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Randomized bench for rf_dump_reader against a word-list model of the dump.
module tb_rf_dump_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [4:0]  first_addr;
   logic [4:0]  last_addr;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_addr;
   logic [31:0] out_data;
   logic        out_last;
   logic        busy;
   logic        done;

   logic [31:0] rf [32];
   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;
   int exp_done = 0;

   always #5 clk = ~clk;

   assign rd_data = rf[rd_addr];

   rf_dump_reader #(.A_WIDTH(5), .D_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .first_addr(first_addr), .last_addr(last_addr),
      .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_addr(out_addr), .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
   );

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_busy"},  64'(busy),      64'd0);
      check({tag, "_done"},  64'(done),      64'd0);
      check({tag, "_rdaddr"},64'(rd_addr),   64'd0);
      check({tag, "_oaddr"}, 64'(out_addr),  64'd0);
      check({tag, "_odata"}, 64'(out_data),  64'd0);
      check({tag, "_olast"}, 64'(out_last),  64'd0);
   endtask

   // One dump: expected word list is the index range with values snapshotted from rf.
   task automatic dump(input logic [4:0] f, input logic [4:0] l, input int stall_idx,
                       input int stall_n, input bit rnd_ready, input bit pulse, input int abort_at);
      logic [4:0]  ea [32];
      logic [31:0] ed [32];
      logic [4:0]  span;
      int n, wi, stalled, cyc, busy_cyc, lows;
      bit aborted;
      span = l - f;
      n = int'(span) + 1;
      for (int i = 0; i < n; i++) begin
         ea[i] = f + 5'(i);
         ed[i] = rf[ea[i]];
      end
      @(negedge clk);
      first_addr = f; last_addr = l; start = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      first_addr = 5'($urandom); last_addr = 5'($urandom);
      check("lat_busy",   64'(busy),      64'd1);
      check("lat_valid0", 64'(out_valid), 64'd0);
      check("lat_rdaddr", 64'(rd_addr),   64'(f));
      busy_cyc = 1; lows = 0; wi = 0; stalled = 0; cyc = 0; aborted = 0;
      while (wi < n && cyc < 3000 && !aborted) begin
         @(negedge clk);
         cyc++;
         if (busy) busy_cyc++;
         check("busy_in_dump", 64'(busy), 64'd1);
         check("rd_addr", 64'(rd_addr), 64'(ea[wi]));
         if (out_valid) begin
            check("out_addr", 64'(out_addr), 64'(ea[wi]));
            check("out_data", 64'(out_data), 64'(ed[wi]));
            check("out_last", 64'(out_last), 64'(wi == n - 1));
            if (wi == abort_at) begin
               #1 rst = 1'b1;
               #1 check_reset_vals("abort");
               @(negedge clk);
               rst = 1'b0; out_ready = 1'b0; start = 1'b0;
               aborted = 1;
            end else if (wi == stall_idx && stalled < stall_n) begin
               out_ready = 1'b0;
               if (stalled == 0) begin
                  if (stall_idx + 1 < n) begin
                     rf[ea[stall_idx + 1]] = 32'h0000_DEAD;
                     ed[stall_idx + 1]     = 32'h0000_DEAD;
                  end
                  rf[ea[wi]] = $urandom;
               end
               stalled++;
            end else begin
               out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (!aborted) begin
               if (!out_ready) lows++;
               else wi++;
            end
         end else begin
            out_ready = 1'($urandom_range(0, 1));
         end
         if (!aborted) start = pulse && (wi < n) && 1'($urandom_range(0, 1));
      end
      start = 1'b0;
      if (!aborted) begin
         check("word_count", 64'(wi), 64'(n));
         check("busy_cycles", 64'(busy_cyc), 64'(2 * n + lows));
         @(negedge clk);
         out_ready = 1'b0;
         exp_done++;
         check("done_pulse", 64'(done),      64'd1);
         check("idle_busy",  64'(busy),      64'd0);
         check("idle_valid", 64'(out_valid), 64'd0);
         check("idle_rdaddr",64'(rd_addr),   64'd0);
         @(negedge clk);
         check("done_once",  64'(done),      64'd0);
         check("stay_idle",  64'(busy),      64'd0);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; first_addr = '0; last_addr = '0; out_ready = 1'b0;
      for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 + 32'(i);
      rf[0] = 32'h0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;
      rf[0] = 32'hA000_0000;
      dump(5'd0,  5'd31, -1, 0, 1'b0, 1'b0, -1);
      dump(5'd10, 5'd10, -1, 0, 1'b0, 1'b0, -1);
      dump(5'd30, 5'd1,  -1, 0, 1'b0, 1'b0, -1);
      dump(5'd0,  5'd7,   3, 5, 1'b0, 1'b0, -1);
      check("rf4_written", 64'(rf[4]), 64'h0000_DEAD);
      dump(5'd5,  5'd20, -1, 0, 1'b1, 1'b1, -1);
      dump(5'd0,  5'd31, -1, 0, 1'b0, 1'b0, 7);
      check("abort_no_done", 64'(done_cnt), 64'(exp_done));
      dump(5'd0,  5'd31, -1, 0, 1'b0, 1'b0, -1);
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < 32; i++) rf[i] = $urandom;
         dump(5'($urandom), 5'($urandom), $urandom_range(0, 6), $urandom_range(1, 4),
              1'b1, 1'($urandom_range(0, 1)), -1);
      end
      repeat (2) @(negedge clk);
      check("done_total", 64'(done_cnt), 64'(exp_done));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
